seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 112 +++++++++++
 tb/tb_seq_alu.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with iterative unsigned mul/div behind valid/ready handshakes.
// Optional SEQ_ALU_OVERFLOW_EN adds a registered signed overflow flag for ADD/SUB.
module seq_alu #(
  parameter int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             mext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m, hi, lo, hi_n, lo_n, fast, res_n;
  logic [WIDTH:0] msum, sh;
  logic [SHW-1:0] sa;
  logic [1:0] sel;
  logic iter, ge, accept;
  assign sa = b[SHW-1:0];
  assign iter = mext && (op[2:0] == 3'b000 || op[2:0] == 3'b011 ||
                         op[2:0] == 3'b101 || op[2:0] == 3'b111);
  assign in_ready = state == IDLE;
  assign busy = state == CALC;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
  always_comb begin
    fast = '0;
    if (!mext)
      case (op)
        4'b0000: fast = a + b;
        4'b1000: fast = a - b;
        4'b0111: fast = a & b;
        4'b0110: fast = a | b;
        4'b0100: fast = a ^ b;
        4'b0001: fast = a << sa;
        4'b0101: fast = a >> sa;
        4'b1101: fast = $signed(a) >>> sa;
        4'b0010: fast = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        4'b0011: fast = {{(WIDTH-1){1'b0}}, a < b};
        default: fast = '0;
      endcase
  end
  // sel[1]: divide (restoring) vs multiply (shift-add); sel[0]: result from hi vs lo
  always_comb begin
    msum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    sh = {hi, lo[WIDTH-1]};
    ge = sh >= {1'b0, m};
    hi_n = sel[1] ? (ge ? sh[WIDTH-1:0] - m : sh[WIDTH-1:0]) : msum[WIDTH:1];
    lo_n = sel[1] ? {lo[WIDTH-2:0], ge} : {msum[0], lo[WIDTH-1:1]};
    res_n = sel[0] ? hi_n : lo_n;
  end
  always_comb
    state_n = accept ? (iter ? CALC : DONE) :
              (state == CALC && cnt == CNT_W'(1)) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      out <= '0;
      zero <= 1'b1;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      sel <= '0;
`ifdef SEQ_ALU_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        sel <= op[2:1];
        m <= op[2] ? b : a;
        lo <= op[2] ? a : b;
        hi <= '0;
        cnt <= CNT_W'(WIDTH);
        if (!iter) begin
          out <= fast;
          zero <= fast == '0;
        end
`ifdef SEQ_ALU_OVERFLOW_EN
        overflow <= !mext && fast[WIDTH-1] != a[WIDTH-1] &&
                    ((op == 4'b0000 && a[WIDTH-1] == b[WIDTH-1]) ||
                     (op == 4'b1000 && a[WIDTH-1] != b[WIDTH-1]));
`endif
      end
      if (state == CALC) begin
        hi <= hi_n;
        lo <= lo_n;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          out <= res_n;
          zero <= res_n == '0;
        end
      end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=64 (single-cycle ops) and WIDTH=8 (iterative, handshake, reset).
module tb_seq_alu;
  logic clk = 0, reset = 1;
  logic iv64 = 0, ir64, ov64, z64, bz64;
  logic [3:0] op64 = 0;
  logic [63:0] a64 = 0, b64 = 0, o64;
  logic iv8 = 0, ir8, ov8, z8, bz8, mx8 = 0, or8 = 1;
  logic [3:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, o8;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf64, ovf8;
`endif
  int n = 0, bad = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(64)) u64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .op(op64), .mext(1'b0), .out_valid(ov64), .out_ready(1'b1), .out(o64), .zero(z64),
    .busy(bz64)
`ifdef SEQ_ALU_OVERFLOW_EN
    , .overflow(ovf64)
`endif
  );

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .op(op8), .mext(mx8), .out_valid(ov8), .out_ready(or8), .out(o8), .zero(z8),
    .busy(bz8)
`ifdef SEQ_ALU_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go64(input string tag, input logic [3:0] o, input logic [63:0] x, input logic [63:0] y,
                      input logic [63:0] e);
    @(negedge clk);
    op64 = o; a64 = x; b64 = y; iv64 = 1;
    @(posedge clk);
    #1 iv64 = 0;
    chk({tag, " valid"}, 64'(ov64), 64'd1);
    chk({tag, " out"}, o64, e);
    chk({tag, " zero"}, 64'(z64), 64'(e == 0));
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input string tag, input logic [3:0] o, input logic mx, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] e, input logic it);
    @(negedge clk);
    op8 = o; mx8 = mx; a8 = x; b8 = y; iv8 = 1;
    @(posedge clk);
    #1 iv8 = 0;
    if (it) begin
      chk({tag, " busy"}, 64'(bz8), 64'd1);
      repeat (7) @(posedge clk);
      #1 chk({tag, " early"}, 64'(ov8), 64'd0);
      @(posedge clk);
      #1;
    end
    chk({tag, " valid"}, 64'(ov8), 64'd1);
    chk({tag, " out"}, 64'(o8), 64'(e));
    chk({tag, " zero"}, 64'(z8), 64'(e == 0));
    @(posedge clk);
    #1 chk({tag, " in_ready"}, 64'(ir8), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(ir8), 64'd1);
    chk("rst out_valid", 64'(ov8), 64'd0);
    chk("rst busy", 64'(bz8), 64'd0);
    chk("rst out", 64'(o8), 64'd0);
    chk("rst zero", 64'(z8), 64'd1);
    chk("rst out64", o64, 64'd0);
    @(negedge clk);
    reset = 0;
    go64("add00", 4'b0000, 64'd0, 64'd0, 64'd0);
    go64("add12", 4'b0000, 64'd1, 64'd2, 64'd3);
    go64("sub45", 4'b1000, 64'd4, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    go64("slt45", 4'b0010, 64'd4, 64'd5, 64'd1);
    go64("sltu54", 4'b0011, 64'd5, 64'd4, 64'd0);
    go64("slt_neg", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    go64("sra", 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
    go64("srl", 4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
    go64("sll_wrap", 4'b0001, 64'd3, 64'd65, 64'd6);
    go64("xor", 4'b0100, 64'hF0F0, 64'hFF00, 64'h0FF0);
    go64("bad_op", 4'b1001, 64'd7, 64'd9, 64'd0);
    go8("mul", 4'b1000, 1'b1, 8'h0F, 8'h11, 8'hFF, 1'b1);
    go8("mulhu", 4'b0011, 1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    go8("mul_lo", 4'b0000, 1'b1, 8'hFF, 8'hFF, 8'h01, 1'b1);
    go8("mul_zero", 4'b0000, 1'b1, 8'h00, 8'h05, 8'h00, 1'b1);
    go8("divu", 4'b0101, 1'b1, 8'd200, 8'd7, 8'd28, 1'b1);
    go8("remu", 4'b0111, 1'b1, 8'd200, 8'd7, 8'd4, 1'b1);
    go8("divu0", 4'b0101, 1'b1, 8'h35, 8'h00, 8'hFF, 1'b1);
    go8("remu0", 4'b0111, 1'b1, 8'h35, 8'h00, 8'h35, 1'b1);
    go8("mext_bad", 4'b0001, 1'b1, 8'h12, 8'h34, 8'h00, 1'b0);
    or8 = 0;
    @(negedge clk);
    op8 = 4'b0000; mx8 = 0; a8 = 8'h12; b8 = 8'h34; iv8 = 1;
    @(posedge clk);
    #1 a8 = 8'h01; b8 = 8'h01;
    for (int i = 0; i < 5; i++) begin
      chk("bp out", 64'(o8), 64'h46);
      chk("bp valid", 64'(ov8), 64'd1);
      chk("bp in_ready", 64'(ir8), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    iv8 = 0; or8 = 1;
    @(posedge clk);
    #1;
    chk("bp release in_ready", 64'(ir8), 64'd1);
    chk("bp release valid", 64'(ov8), 64'd0);
    chk("bp release out", 64'(o8), 64'h46);
    @(negedge clk);
    op8 = 4'b0000; mx8 = 1; a8 = 8'h0F; b8 = 8'h11; iv8 = 1;
    @(posedge clk);
    #1 iv8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrst valid", 64'(ov8), 64'd0);
    chk("midrst in_ready", 64'(ir8), 64'd1);
    chk("midrst out", 64'(o8), 64'd0);
    chk("midrst busy", 64'(bz8), 64'd0);
    chk("midrst zero", 64'(z8), 64'd1);
    @(negedge clk);
    reset = 0;
    go8("post_rst_divu", 4'b0101, 1'b1, 8'd100, 8'd9, 8'd11, 1'b1);
`ifdef SEQ_ALU_OVERFLOW_EN
    @(negedge clk);
    op8 = 4'b0000; mx8 = 0; a8 = 8'h7F; b8 = 8'h01; iv8 = 1;
    @(posedge clk);
    #1 iv8 = 0;
    chk("ovf out", 64'(o8), 64'h80);
    chk("ovf flag", 64'(ovf8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    op8 = 4'b1000; a8 = 8'h05; b8 = 8'h03; iv8 = 1;
    @(posedge clk);
    #1 iv8 = 0;
    chk("noovf flag", 64'(ovf8), 64'd0);
    @(posedge clk);
`endif
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
